// File: rtl/dna_population_initializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dna_pkg
// Purpose  : Shared types and helpers for the population DNA seeder and the
//            network evaluator. Provides the run-mode encodings, the
//            initializer FSM state type, the RAM instruction encodings and
//            the genome-size helper.
// Revision : 1.0 - initial release
// ============================================================================
package dna_pkg;

  // Run modes: bit 0 selects a single network, bit 1 selects constant fill.
  typedef enum logic [1:0] {
    MODE_RANDOM_ALL = 2'd0,
    MODE_RANDOM_ONE = 2'd1,
    MODE_CONST_ALL  = 2'd2,
    MODE_CONST_ONE  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Level driven on ramInstruction.
  typedef enum logic {
    RAM_READ  = 1'b0,
    RAM_WRITE = 1'b1
  } ram_instr_e;

  // Genes per network: one bias-like gene per output plus one per neuron input.
  function automatic int genes_per_net(input int outputCount,
                                       input int neuronCount,
                                       input int connections);
    return outputCount + neuronCount * connections;
  endfunction

  function automatic logic mode_is_one(input mode_e m);
    return (m == MODE_RANDOM_ONE) || (m == MODE_CONST_ONE);
  endfunction

  function automatic logic mode_is_const(input mode_e m);
    return (m == MODE_CONST_ALL) || (m == MODE_CONST_ONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dna_population_initializer_if.sv
`default_nettype none
// ============================================================================
// Module   : dna_population_initializer_if
// Purpose  : Control handshake between a run requester (master) and the
//            population initializer (slave).
// Ports    : start      - one-cycle run request
//            mode       - run mode, captured at start
//            netSel     - target network for single-network modes
//            fillValue  - constant written in the fill modes
//            finished   - level, set when a run completes
//            selError   - level, set when netSel was out of range
// Revision : 1.0 - initial release
// ============================================================================
interface dna_population_initializer_if
  import dna_pkg::*;
#(
  parameter int SEL_W = 4
) ();

  logic             start;
  mode_e            mode;
  logic [SEL_W-1:0] netSel;
  logic [15:0]      fillValue;
  logic             finished;
  logic             selError;

  modport master (
    output start, mode, netSel, fillValue,
    input  finished, selError
  );

  modport slave (
    input  start, mode, netSel, fillValue,
    output finished, selError
  );

endinterface
`default_nettype wire

// File: rtl/dna_population_initializer_gene_range_mapper.sv
`default_nettype none
// ============================================================================
// Module   : gene_range_mapper
// Purpose  : Maps a uniform RAND_WIDTH-bit random value onto [0, GENE_RANGE-1]
//            as (random * GENE_RANGE) >> RAND_WIDTH. Purely combinational.
// Ports    : i_randomNum - raw random value
//            o_geneValue - mapped gene, zero-extended to 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module gene_range_mapper #(
  parameter int RAND_WIDTH = 9,
  parameter int GENE_RANGE = 4
) (
  input  wire logic [RAND_WIDTH-1:0] i_randomNum,
  output logic      [15:0]           o_geneValue
);

  // Full product width: GENE_RANGE never exceeds 16 bits, so nothing is lost
  // before the shift.
  localparam int c_prodW = RAND_WIDTH + 16;
  localparam logic [c_prodW-1:0] c_range = c_prodW'(GENE_RANGE);

  if (GENE_RANGE < 1 || GENE_RANGE > 65535) begin : g_rangeCheck
    $error("gene_range_mapper: GENE_RANGE must lie in 1..65535");
  end

  logic [c_prodW-1:0] w_product;
  logic               w_unusedLow;

  assign w_product   = c_prodW'(i_randomNum) * c_range;
  assign o_geneValue = w_product[RAND_WIDTH +: 16];
  // The fractional part of the product is discarded by the shift.
  assign w_unusedLow = ^w_product[RAND_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/dna_population_initializer.sv
`default_nettype none
// ============================================================================
// Module   : dna_population_initializer
// Purpose  : Writes initial genomes (random or constant) for the whole
//            population or for one network into external RAM over the shared
//            tri-state bus. The bus is driven only while networkState == 0.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            ctrl            - start/mode/netSel/fillValue in,
//                              finished/selError out
//            networkState    - bus ownership (owned when 0)
//            randomNum       - free-running random source
//            ramBusDataIn    - tri-state write data
//            ramBusAddr      - tri-state word address
//            ramLatch        - tri-state one-cycle write strobe
//            ramReady        - RAM can accept a write
//            ramInstruction  - tri-state, WRITE while owned
// Revision : 1.0 - initial release
// ============================================================================
module dna_population_initializer
  import dna_pkg::*;
#(
  parameter int INPUT_COUNT             = 1,
  parameter int OUTPUT_COUNT            = 1,
  parameter int NEURON_COUNT            = 2,
  parameter int CONNECTIONS             = 2,
  parameter int NETWORKS_PER_POPULATION = 16,
  parameter int GENE_RANGE              = OUTPUT_COUNT + NEURON_COUNT + 1,
  parameter int RAND_WIDTH              = 9,
  parameter int BASE_ADDR               = 0
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  dna_population_initializer_if.slave ctrl,
  input  wire logic [1:0]            networkState,
  input  wire logic [RAND_WIDTH-1:0] randomNum,
  inout  wire       [15:0]           ramBusDataIn,
  inout  wire       [23:1]           ramBusAddr,
  inout  wire                        ramLatch,
  input  wire logic                  ramReady,
  inout  wire                        ramInstruction
);

  localparam int c_genes = genes_per_net(OUTPUT_COUNT, NEURON_COUNT, CONNECTIONS);
  localparam int c_geneW = (c_genes > 1) ? $clog2(c_genes) : 1;
  localparam int c_selW  = (NETWORKS_PER_POPULATION > 1) ? $clog2(NETWORKS_PER_POPULATION) : 1;
  localparam logic [c_geneW-1:0] c_lastGene = c_geneW'(c_genes - 1);
  localparam logic [c_selW-1:0]  c_lastNet  = c_selW'(NETWORKS_PER_POPULATION - 1);
  localparam logic [22:0] c_baseAddr  = 23'(BASE_ADDR);
  localparam logic [22:0] c_genesAddr = 23'(c_genes);
  localparam longint c_addrEnd = longint'(BASE_ADDR) +
                                 longint'(NETWORKS_PER_POPULATION) * longint'(c_genes);

  // ---------------------------------------------------------------- checks
  if (c_addrEnd > (longint'(1) << 23)) begin : g_addrCheck
    $error("dna_population_initializer: population does not fit the 23-bit address space");
  end
  if (INPUT_COUNT < 1 || OUTPUT_COUNT < 1 || NEURON_COUNT < 1 ||
      CONNECTIONS < 1 || NETWORKS_PER_POPULATION < 1) begin : g_paramCheck
    $error("dna_population_initializer: all counts must be at least 1");
  end

  // ---------------------------------------------------------------- state
  state_e              r_state;
  state_e              w_nextState;
  mode_e               r_mode;
  logic [15:0]         r_fill;
  logic [22:0]         r_addr;
  logic [15:0]         r_data;
  logic [c_geneW-1:0]  r_gene;
  logic [c_selW-1:0]   r_net;
  logic                r_finished;
  logic                r_selError;
  logic                r_selPending;

  logic                w_own;
  logic                w_latch;
  logic                w_selOutOfRange;
  logic                w_selBad;
  logic                w_lastWrite;
  logic [22:0]         w_startAddr;
  logic [15:0]         w_geneValue;
  logic [15:0]         w_issueData;
  logic [15:0]         w_data;

  assign w_own = (networkState == 2'd0);

  // When netSel can encode exactly the population size, it can never be out
  // of range and the comparison would be constant.
  if (NETWORKS_PER_POPULATION == (1 << c_selW)) begin : g_selFull
    assign w_selOutOfRange = 1'b0;
  end else begin : g_selPartial
    assign w_selOutOfRange = (ctrl.netSel >= c_selW'(NETWORKS_PER_POPULATION));
  end
  assign w_selBad = mode_is_one(ctrl.mode) && w_selOutOfRange;

  // Genomes are contiguous, so the address is loaded once and then just
  // incremented after every write.
  assign w_startAddr = c_baseAddr +
                       (mode_is_one(ctrl.mode) ? 23'(ctrl.netSel) * c_genesAddr : 23'd0);

  assign w_lastWrite = (r_gene == c_lastGene) &&
                       (mode_is_one(r_mode) || (r_net == c_lastNet));

  gene_range_mapper #(
    .RAND_WIDTH (RAND_WIDTH),
    .GENE_RANGE (GENE_RANGE)
  ) u_mapper (
    .i_randomNum (randomNum),
    .o_geneValue (w_geneValue)
  );

  assign w_issueData = mode_is_const(r_mode) ? r_fill : w_geneValue;
  // In ISSUE the data tracks the live random value so the one sampled at the
  // latch cycle is what gets written; HOLD replays the captured copy.
  assign w_data = (r_state == ST_ISSUE) ? w_issueData : r_data;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    w_nextState = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ctrl.start) begin
          w_nextState = w_selBad ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ramReady && w_own) begin
          w_latch     = 1'b1;
          w_nextState = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_nextState = w_lastWrite ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_RANDOM_ALL;
      r_fill       <= 16'd0;
      r_addr       <= 23'd0;
      r_data       <= 16'd0;
      r_gene       <= '0;
      r_net        <= '0;
      r_finished   <= 1'b0;
      r_selError   <= 1'b0;
      r_selPending <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        ST_IDLE: begin
          if (ctrl.start) begin
            r_finished   <= 1'b0;
            r_selError   <= 1'b0;
            r_selPending <= w_selBad;
            r_mode       <= ctrl.mode;
            r_fill       <= ctrl.fillValue;
            r_addr       <= w_startAddr;
            r_gene       <= '0;
            r_net        <= '0;
          end
        end
        ST_ISSUE: begin
          if (w_latch) begin
            r_data <= w_issueData;
          end
        end
        ST_HOLD: begin
          r_addr <= r_addr + 23'd1;
          if (r_gene == c_lastGene) begin
            r_gene <= '0;
            r_net  <= r_net + 1'b1;
          end else begin
            r_gene <= r_gene + 1'b1;
          end
        end
        ST_DONE: begin
          r_finished <= 1'b1;
          r_selError <= r_selPending;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign ctrl.finished = r_finished;
  assign ctrl.selError = r_selError;

  assign ramLatch       = w_own ? w_latch   : 1'bz;
  assign ramInstruction = w_own ? RAM_WRITE : 1'bz;
  assign ramBusAddr     = w_own ? r_addr    : 23'bz;
  assign ramBusDataIn   = w_own ? w_data    : 16'bz;

endmodule
`default_nettype wire

// File: tb/tb_dna_population_initializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dna_population_initializer
// Purpose  : Self-checking bench for dna_population_initializer. A default
//            instance (A) and a 5-network instance (B) are driven with
//            directed runs; expected writes are queued at start and a monitor
//            pops and compares every observed ramLatch strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dna_population_initializer;
  import dna_pkg::*;

  typedef struct {
    logic [22:0] addr;
    logic        isConst;
    logic [15:0] fill;
    int          range;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [8:0] rnd = 9'd0;
  int errors = 0;
  int checks = 0;
  int writesA = 0;
  int writesB = 0;
  exp_t qA[$];
  exp_t qB[$];
  int hist[5];
  int badMap;
  int k, fl, n;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT A
  dna_population_initializer_if #(.SEL_W(4)) ctrlA ();
  logic [1:0] nsA = 2'd0;
  logic readyA = 1'b1;
  wire [15:0] dataA;
  wire [23:1] addrA;
  wire        latchA;
  wire        instrA;
  logic       parkA;

  // Another bus master parks the bus at zero while it owns it.
  assign parkA  = (nsA != 2'd0);
  assign dataA  = parkA ? 16'h0000 : 16'hzzzz;
  assign addrA  = parkA ? 23'd0 : 23'bz;
  assign latchA = parkA ? 1'b0 : 1'bz;
  assign instrA = parkA ? 1'b0 : 1'bz;

  dna_population_initializer dutA (
    .clk            (clk),
    .rst            (rst),
    .ctrl           (ctrlA),
    .networkState   (nsA),
    .randomNum      (rnd),
    .ramBusDataIn   (dataA),
    .ramBusAddr     (addrA),
    .ramLatch       (latchA),
    .ramReady       (readyA),
    .ramInstruction (instrA)
  );

  // ---------------------------------------------------------------- DUT B
  dna_population_initializer_if #(.SEL_W(3)) ctrlB ();
  logic [1:0] nsB = 2'd0;
  logic readyB = 1'b1;
  wire [15:0] dataB;
  wire [23:1] addrB;
  wire        latchB;
  wire        instrB;

  dna_population_initializer #(
    .NETWORKS_PER_POPULATION (5),
    .GENE_RANGE              (5),
    .BASE_ADDR               (100)
  ) dutB (
    .clk            (clk),
    .rst            (rst),
    .ctrl           (ctrlB),
    .networkState   (nsB),
    .randomNum      (rnd),
    .ramBusDataIn   (dataB),
    .ramBusAddr     (addrB),
    .ramLatch       (latchB),
    .ramReady       (readyB),
    .ramInstruction (instrB)
  );

  // ---------------------------------------------------------------- mapper
  logic [8:0]  sweep = 9'd0;
  logic [15:0] mapped;
  gene_range_mapper #(.RAND_WIDTH(9), .GENE_RANGE(5)) u_map (
    .i_randomNum (sweep),
    .o_geneValue (mapped)
  );

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic checkWrite(input int d, input logic [22:0] a, input logic [15:0] dt);
    exp_t e;
    logic [15:0] want;
    int qs;
    checks++;
    if (d == 0) writesA++; else writesB++;
    qs = (d == 0) ? qA.size() : qB.size();
    if (qs == 0) begin
      errors++;
      $display("FAIL unexpected_write dut%0d actual addr=%0d data=%h required=no write", d, a, dt);
    end else begin
      if (d == 0) e = qA.pop_front(); else e = qB.pop_front();
      want = e.isConst ? e.fill : 16'((int'(rnd) * e.range) >> 9);
      if (a !== e.addr || dt !== want) begin
        errors++;
        $display("FAIL write dut%0d actual addr=%0d data=%h required addr=%0d data=%h",
                 d, a, dt, e.addr, want);
      end
    end
  endtask

  // Monitor: every strobe seen on either bus is matched against the queue.
  always @(negedge clk) begin
    if (latchA === 1'b1) checkWrite(0, addrA, dataA);
    if (latchB === 1'b1) checkWrite(1, addrB, dataB);
  end

  // Free-running random source (full-period LCG mod 512).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd = rnd * 9'd109 + 9'd71;
    end
  end

  task automatic pushRun(input int d, input mode_e m, input int sel, input logic [15:0] fill);
    exp_t e;
    int base, nets, first, last;
    base  = (d == 0) ? 0 : 100;
    nets  = (d == 0) ? 16 : 5;
    first = mode_is_one(m) ? sel : 0;
    last  = mode_is_one(m) ? sel : nets - 1;
    for (int nn = first; nn <= last; nn++) begin
      for (int g = 0; g < 5; g++) begin
        e.addr    = 23'(base + nn * 5 + g);
        e.isConst = mode_is_const(m);
        e.fill    = fill;
        e.range   = (d == 0) ? 4 : 5;
        if (d == 0) qA.push_back(e); else qB.push_back(e);
      end
    end
  endtask

  // Called #1 after a posedge; returns #1 after the posedge that sampled start.
  task automatic startA(input mode_e m, input int sel, input logic [15:0] fill);
    pushRun(0, m, sel, fill);
    ctrlA.mode      = m;
    ctrlA.netSel    = 4'(sel);
    ctrlA.fillValue = fill;
    ctrlA.start     = 1'b1;
    @(posedge clk);
    #1;
    ctrlA.start = 1'b0;
  endtask

  task automatic startB(input mode_e m, input int sel, input logic push);
    if (push) pushRun(1, m, sel, 16'h0000);
    ctrlB.mode      = m;
    ctrlB.netSel    = 3'(sel);
    ctrlB.fillValue = 16'h0000;
    ctrlB.start     = 1'b1;
    @(posedge clk);
    #1;
    ctrlB.start = 1'b0;
  endtask

  // Runs A until finished. cyc counts cycles from the start cycle; optional
  // ramReady toggling and a 10-cycle bus outage starting at cycle outAt.
  task automatic runA(input logic toggle, input int outAt,
                      output int cyc, output int firstLatch, output int nLatch);
    cyc = 1;
    firstLatch = -1;
    nLatch = 0;
    forever begin
      @(negedge clk);
      if (latchA === 1'b1) begin
        nLatch++;
        if (firstLatch < 0) firstLatch = cyc;
      end
      if (nsA != 2'd0) begin
        chk("outage_latch", {31'd0, latchA}, 32'd0);
        chk("outage_addr", {9'd0, addrA}, 32'd0);
        chk("outage_instr", {31'd0, instrA}, 32'd0);
      end
      if (ctrlA.finished === 1'b1) break;
      if (cyc > 2000) begin
        chk("run_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (toggle) readyA = ~readyA;
      if (cyc == outAt) nsA = 2'd2;
      if (cyc == outAt + 10) nsA = 2'd0;
    end
    readyA = 1'b1;
    nsA = 2'd0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    ctrlA.start = 1'b0; ctrlA.mode = MODE_RANDOM_ALL; ctrlA.netSel = '0; ctrlA.fillValue = '0;
    ctrlB.start = 1'b0; ctrlB.mode = MODE_RANDOM_ALL; ctrlB.netSel = '0; ctrlB.fillValue = '0;

    // Mapper sweep with GENE_RANGE=5: bucket sizes 103,102,103,102,102.
    for (int i = 0; i < 5; i++) hist[i] = 0;
    badMap = 0;
    for (int r = 0; r < 512; r++) begin
      sweep = 9'(r);
      #1;
      if (mapped < 16'd5) hist[mapped]++; else badMap++;
    end
    chk("map_out_of_range", 32'(badMap), 32'd0);
    chk("map_hist0", 32'(hist[0]), 32'd103);
    chk("map_hist1", 32'(hist[1]), 32'd102);
    chk("map_hist2", 32'(hist[2]), 32'd103);
    chk("map_hist3", 32'(hist[3]), 32'd102);
    chk("map_hist4", 32'(hist[4]), 32'd102);
    sweep = 9'd511; #1; chk("map_511", 32'(mapped), 32'd4);
    sweep = 9'd103; #1; chk("map_103", 32'(mapped), 32'd1);
    sweep = 9'd102; #1; chk("map_102", 32'(mapped), 32'd0);

    // Reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_finished", {31'd0, ctrlA.finished}, 32'd0);
    chk("rst_selError", {31'd0, ctrlA.selError}, 32'd0);
    chk("rst_latch", {31'd0, latchA}, 32'd0);
    chk("rst_addr", {9'd0, addrA}, 32'd0);
    chk("rst_data", {16'd0, dataA}, 32'd0);
    chk("rst_instr", {31'd0, instrA}, 32'd1);
    chk("rst_selErrorB", {31'd0, ctrlB.selError}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // RANDOM_ALL: 80 writes at 0..79, finished on cycle 162.
    startA(MODE_RANDOM_ALL, 0, 16'h0000);
    runA(1'b0, -1, k, fl, n);
    chk("ra_finish_cycle", 32'(k), 32'd162);
    chk("ra_first_latch", 32'(fl), 32'd1);
    chk("ra_latch_count", 32'(n), 32'd80);
    chk("ra_queue_empty", 32'(qA.size()), 32'd0);
    @(posedge clk);
    #1;

    // CONST_ONE netSel=3: addresses 15..19; inputs changed mid-run are ignored.
    startA(MODE_CONST_ONE, 3, 16'hABCD);
    ctrlA.mode = MODE_RANDOM_ALL;
    ctrlA.netSel = 4'd0;
    ctrlA.fillValue = 16'h1234;
    runA(1'b0, -1, k, fl, n);
    chk("co_finish_cycle", 32'(k), 32'd12);
    chk("co_latch_count", 32'(n), 32'd5);
    chk("co_queue_empty", 32'(qA.size()), 32'd0);
    @(posedge clk);
    #1;

    // CONST_ALL with ramReady toggling and a 10-cycle bus outage.
    startA(MODE_CONST_ALL, 0, 16'h5A5A);
    runA(1'b1, 20, k, fl, n);
    chk("out_latch_count", 32'(n), 32'd80);
    chk("out_queue_empty", 32'(qA.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset during HOLD of write 7, then a fresh run from BASE_ADDR.
    startA(MODE_RANDOM_ALL, 0, 16'h0000);
    n = 0;
    k = 0;
    forever begin
      @(negedge clk);
      if (latchA === 1'b1) n++;
      if (n == 7) break;
      if (k > 200) begin
        chk("rst7_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("hold7_addr", {9'd0, addrA}, 32'd6);
    chk("hold7_latch", {31'd0, latchA}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    qA.delete();
    @(negedge clk);
    chk("post_rst_latch", {31'd0, latchA}, 32'd0);
    chk("post_rst_finished", {31'd0, ctrlA.finished}, 32'd0);
    chk("post_rst_addr", {9'd0, addrA}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    startA(MODE_CONST_ALL, 0, 16'h0F0F);
    runA(1'b0, -1, k, fl, n);
    chk("restart_finish_cycle", 32'(k), 32'd162);
    chk("restart_latch_count", 32'(n), 32'd80);
    chk("restart_queue_empty", 32'(qA.size()), 32'd0);

    // DUT B: netSel=6 out of a 5-network population.
    startB(MODE_RANDOM_ONE, 6, 1'b0);
    @(negedge clk);
    chk("sel_t1_selError", {31'd0, ctrlB.selError}, 32'd0);
    chk("sel_t1_finished", {31'd0, ctrlB.finished}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("sel_t2_selError", {31'd0, ctrlB.selError}, 32'd1);
    chk("sel_t2_finished", {31'd0, ctrlB.finished}, 32'd1);
    chk("sel_no_write", 32'(writesB), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // DUT B: valid RANDOM_ONE on the last network, addresses 120..124.
    startB(MODE_RANDOM_ONE, 4, 1'b1);
    @(negedge clk);
    chk("b_selError_cleared", {31'd0, ctrlB.selError}, 32'd0);
    k = 1;
    while (ctrlB.finished !== 1'b1 && k <= 200) begin
      @(posedge clk);
      #1;
      k++;
      @(negedge clk);
    end
    chk("b_finish_cycle", 32'(k), 32'd12);
    chk("b_write_count", 32'(writesB), 32'd5);
    chk("b_queue_empty", 32'(qB.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
